// File: rtl/register_file.sv
// Integer register file: DEPTH x WIDTH storage, two combinational read ports,
// one synchronous write port decoded by Hot_Bit, x0 hardwired to zero.
module register_file #(
    parameter int unsigned  DEPTH  = 32,
    parameter int unsigned  WIDTH  = 32,
    parameter bit           BYPASS = 1'b1,
    localparam int unsigned ABITS  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ABITS-1:0] rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [ABITS-1:0] rs1_addr,
    output logic [WIDTH-1:0] rs1_data,
    input  logic [ABITS-1:0] rs2_addr,
    output logic [WIDTH-1:0] rs2_data,
    input  logic [ABITS-1:0] dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [15:0]      wr_count
);

    localparam int unsigned   CW   = 16;
    localparam logic [CW-1:0] CMAX = '1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("register_file: DEPTH must be a power of two and at least 2");
    end

    logic [DEPTH-1:0] wr_onehot;
    logic [WIDTH-1:0] regs [1:DEPTH-1];
    logic             commit;
    logic             wr_live;
    logic             rs1_hit;
    logic             rs2_hit;
    logic [WIDTH-1:0] rs1_stored;
    logic [WIDTH-1:0] rs2_stored;
    logic [WIDTH-1:0] dbg_stored;

    Hot_Bit #(.N(DEPTH)) u_hot_bit (
        .addr   (rd_addr),
        .onehot (wr_onehot)
    );

    // A write to x0 is dropped, so it neither commits nor counts.
    assign commit = we & ~wr_onehot[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (we && wr_onehot[i]) begin
                    regs[i] <= rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (commit && (wr_count != CMAX)) begin
            wr_count <= wr_count + CW'(1);
        end
    end

    // Stored-value read muxes; address 0 falls through to zero.
    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        dbg_stored = '0;
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (rs1_addr == ABITS'(i)) begin
                rs1_stored = regs[i];
            end
            if (rs2_addr == ABITS'(i)) begin
                rs2_stored = regs[i];
            end
            if (dbg_addr == ABITS'(i)) begin
                dbg_stored = regs[i];
            end
        end
    end

    // Bypass only when a real (nonzero) write is in flight this cycle.
    assign wr_live = BYPASS ? commit : 1'b0;
    assign rs1_hit = wr_live & (rs1_addr == rd_addr);
    assign rs2_hit = wr_live & (rs2_addr == rd_addr);

    assign rs1_data = rs1_hit ? rd_data : rs1_stored;
    assign rs2_data = rs2_hit ? rd_data : rs2_stored;
    assign dbg_data = dbg_stored;

endmodule

// Hot_Bit: binary address to one-hot select, N outputs.
module Hot_Bit #(
    parameter int unsigned  N  = 32,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            onehot[i] = (addr == AW'(i));
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table vectors, hand sequences,
// random traffic against an array model, and wr_count saturation.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dbg_addr;

    logic [31:0] b_rs1, b_rs2, b_dbg;
    logic [15:0] b_cnt;
    logic [31:0] n_rs1, n_rs2, n_dbg;
    logic [15:0] n_cnt;

    int compared = 0;
    int failed   = 0;

    logic [31:0] mdl [32];
    int          mcnt;

    register_file #(.DEPTH(32), .WIDTH(32), .BYPASS(1'b1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs1_data (b_rs1),
        .rs2_addr (rs2_addr),
        .rs2_data (b_rs2),
        .dbg_addr (dbg_addr),
        .dbg_data (b_dbg),
        .wr_count (b_cnt)
    );

    register_file #(.DEPTH(32), .WIDTH(32), .BYPASS(1'b0)) u_dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_addr (rs1_addr),
        .rs1_data (n_rs1),
        .rs2_addr (rs2_addr),
        .rs2_data (n_rs2),
        .dbg_addr (dbg_addr),
        .dbg_data (n_dbg),
        .wr_count (n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  dbg_addr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_dbg;
        logic [31:0] e_nrs1;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stored(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mdl[a];
    endfunction

    // Architectural read: bypass applies to a nonzero in-flight write only.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (byp && we && (rd_addr != 5'd0) && (a == rd_addr)) return rd_data;
        return stored(a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mcnt = 0;
    endtask

    // Update the model from the inputs present before the edge, then clock.
    task automatic step();
        if (rst_n && we && (rd_addr != 5'd0)) begin
            mdl[rd_addr] = rd_data;
            if (mcnt < 65535) mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rs1"},    b_rs1, exp_read(rs1_addr, 1'b1));
        chk({tag, ".rs2"},    b_rs2, exp_read(rs2_addr, 1'b1));
        chk({tag, ".dbg"},    b_dbg, stored(dbg_addr));
        chk({tag, ".nb_rs1"}, n_rs1, exp_read(rs1_addr, 1'b0));
        chk({tag, ".nb_rs2"}, n_rs2, exp_read(rs2_addr, 1'b0));
        chk({tag, ".cnt"},    {16'd0, b_cnt}, 32'(mcnt));
    endtask

    task automatic drive(input logic w, input logic [4:0] rd, input logic [31:0] d,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        we = w; rd_addr = rd; rd_data = d;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
    endtask

    initial begin
        logic [31:0] v;
        bit          seen_fffe;

        model_clear();
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5);
        #2;
        chk("por.rs1", b_rs1, 32'd0);
        chk("por.cnt", {16'd0, b_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload x5, then assert reset mid-cycle and look before any edge.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
        step();
        we = 1'b0;
        #1;
        chk("preload.rs1", b_rs1, 32'hDEADBEEF);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_async.rs1",    b_rs1, 32'd0);
        chk("rst_async.dbg",    b_dbg, 32'd0);
        chk("rst_async.nb_rs1", n_rs1, 32'd0);
        chk("rst_async.cnt",    {16'd0, b_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while a write to x9 is pending aborts that write.
        drive(1'b1, 5'd9, 32'h55AA55AA, 5'd9, 5'd9, 5'd9);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_bypass.rs1", b_rs1, 32'h55AA55AA);
        chk("rst_bypass.dbg", b_dbg, 32'd0);
        step();
        we = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_abort.rs1", b_rs1, 32'd0);
        chk("rst_abort.cnt", {16'd0, b_cnt}, 32'd0);

        tbl[0] = '{1'b1, 5'd3,  32'h12345678, 5'd3, 5'd31, 5'd3,  32'h12345678, 32'h0,        32'h0,        32'h0,        16'd1};
        tbl[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd3, 5'd31, 5'd3,  32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 16'd2};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd31, 5'd31, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 16'd2};
        tbl[3] = '{1'b1, 5'd0,  32'hAAAAAAAA, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        16'd2};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0, 5'd3,  5'd0,  32'h0,        32'h12345678, 32'h0,        32'h0,        16'd2};
        tbl[5] = '{1'b1, 5'd7,  32'h1,        5'd7, 5'd7,  5'd7,  32'h1,        32'h1,        32'h0,        32'h0,        16'd3};
        tbl[6] = '{1'b1, 5'd7,  32'h2,        5'd7, 5'd7,  5'd7,  32'h2,        32'h2,        32'h1,        32'h1,        16'd4};
        tbl[7] = '{1'b0, 5'd7,  32'h0,        5'd7, 5'd3,  5'd7,  32'h2,        32'h12345678, 32'h2,        32'h2,        16'd4};

        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].we, tbl[k].rd_addr, tbl[k].rd_data,
                  tbl[k].rs1_addr, tbl[k].rs2_addr, tbl[k].dbg_addr);
            #1;
            chk($sformatf("vec%0d.rs1", k),    b_rs1, tbl[k].e_rs1);
            chk($sformatf("vec%0d.rs2", k),    b_rs2, tbl[k].e_rs2);
            chk($sformatf("vec%0d.dbg", k),    b_dbg, tbl[k].e_dbg);
            chk($sformatf("vec%0d.nb_rs1", k), n_rs1, tbl[k].e_nrs1);
            step();
            chk($sformatf("vec%0d.cnt", k),    {16'd0, b_cnt}, {16'd0, tbl[k].e_cnt});
            chk($sformatf("vec%0d.nb_cnt", k), {16'd0, n_cnt}, {16'd0, tbl[k].e_cnt});
        end

        // Decode sweep: each register gets a distinct value, then all are read.
        for (int i = 1; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0, 5'd0);
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            dbg_addr = 5'(i);
            #1;
            v = 32'(i) * 32'h01010101;
            chk($sformatf("sweep.rs1[%0d]", i),    b_rs1, v);
            chk($sformatf("sweep.dbg[%0d]", i),    b_dbg, v);
            chk($sformatf("sweep.nb_rs2[%0d]", i), n_rs2, 32'(31 - i) * 32'h01010101);
        end

        // Random traffic, with reads biased toward the address being written.
        for (int k = 0; k < 500; k++) begin
            we       = 1'($urandom_range(0, 1));
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            dbg_addr = ($urandom_range(0, 2) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            #1;
            check_all($sformatf("rand%0d", k));
            step();
        end

        // Saturation: 65540 nonzero writes pin wr_count at FFFF.
        seen_fffe = 1'b0;
        for (int k = 0; k < 65540; k++) begin
            drive(1'b1, 5'(1 + (k % 31)), 32'(k), 5'd1, 5'd2, 5'd3);
            step();
            if (!seen_fffe && (mcnt == 65534)) begin
                seen_fffe = 1'b1;
                chk("sat.pre", {16'd0, b_cnt}, 32'h0000FFFE);
            end
        end
        chk("sat.cnt",    {16'd0, b_cnt}, 32'h0000FFFF);
        chk("sat.nb_cnt", {16'd0, n_cnt}, 32'h0000FFFF);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd4, 32'hC0FFEE00 + 32'(k), 5'd4, 5'd4, 5'd4);
            step();
        end
        we = 1'b0;
        #1;
        chk("sat.hold",   {16'd0, b_cnt}, 32'h0000FFFF);
        check_all("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
